// File: rtl/rect_fill_writer.sv
// Rectangle fill engine: emits one clipped frame-buffer pixel write per clock, row-major.
// Optional build macro RECT_OUTLINE_EN adds an 'outline' input that limits writes to the border.
module rect_fill_writer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int ADDR_W   = 15,
    parameter int COLOR_W  = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         x0,
    input  logic [6:0]         y0,
    input  logic [7:0]         w,
    input  logic [6:0]         h,
    input  logic [COLOR_W-1:0] color,
`ifdef RECT_OUTLINE_EN
    input  logic               outline,
`endif
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               wr_en
);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, FINISH} state_t;

    localparam logic [8:0]        SCREEN_W9 = 9'(SCREEN_W);
    localparam logic [7:0]        SCREEN_H8 = 8'(SCREEN_H);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(SCREEN_W);

    state_t state, state_n;

    logic [7:0]         x0_q, x0_n;
    logic [6:0]         y0_q, y0_n;
    logic [7:0]         w_q, w_n;
    logic [6:0]         h_q, h_n;
    logic [COLOR_W-1:0] color_q, color_n;
`ifdef RECT_OUTLINE_EN
    logic               outline_q, outline_n;
`endif

    logic [7:0]         x_q, x_n;
    logic [6:0]         y_q, y_n;
    logic [ADDR_W-1:0]  row_base, row_n;

    logic               busy_n, done_n, wr_en_n;
    logic [ADDR_W-1:0]  wr_addr_n;
    logic [COLOR_W-1:0] wr_data_n;

    logic [8:0]         x_sum, x_end, x_last;
    logic [7:0]         y_sum, y_end, y_last;
    logic               empty, at_x_last, at_y_last, emit;
    logic [ADDR_W-1:0]  row_first;

    // Clipped bounds are widened by one bit so x0+w and y0+h never wrap.
    always_comb begin
        x_sum     = {1'b0, x0_q} + {1'b0, w_q};
        y_sum     = {1'b0, y0_q} + {1'b0, h_q};
        x_end     = (x_sum > SCREEN_W9) ? SCREEN_W9 : x_sum;
        y_end     = (y_sum > SCREEN_H8) ? SCREEN_H8 : y_sum;
        x_last    = x_end - 9'd1;
        y_last    = y_end - 8'd1;
        empty     = (w_q == 8'd0) || (h_q == 7'd0) ||
                    ({1'b0, x0_q} >= SCREEN_W9) || ({1'b0, y0_q} >= SCREEN_H8);
        at_x_last = ({1'b0, x_q} == x_last);
        at_y_last = ({1'b0, y_q} == y_last);
        row_first = ADDR_W'(y0_q) * ROW_STEP;
    end

    always_comb begin
        state_n   = state;
        busy_n    = busy;
        done_n    = 1'b0;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        x0_n      = x0_q;
        y0_n      = y0_q;
        w_n       = w_q;
        h_n       = h_q;
        color_n   = color_q;
`ifdef RECT_OUTLINE_EN
        outline_n = outline_q;
`endif
        x_n       = x_q;
        y_n       = y_q;
        row_n     = row_base;
        emit      = 1'b0;

        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    x0_n    = x0;
                    y0_n    = y0;
                    w_n     = w;
                    h_n     = h;
                    color_n = color;
`ifdef RECT_OUTLINE_EN
                    outline_n = outline;
`endif
                    busy_n  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (empty) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = FINISH;
                end else begin
                    x_n     = x0_q;
                    y_n     = y0_q;
                    row_n   = row_first;
                    emit    = 1'b1;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                // Row advance adds one stride instead of multiplying y by the width.
                if (at_x_last) begin
                    if (at_y_last) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = FINISH;
                    end else begin
                        x_n   = x0_q;
                        y_n   = y_q + 7'd1;
                        row_n = row_base + ROW_STEP;
                        emit  = 1'b1;
                    end
                end else begin
                    x_n  = x_q + 8'd1;
                    emit = 1'b1;
                end
            end
            FINISH: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (emit) begin
            wr_addr_n = row_n + ADDR_W'(x_n);
            wr_data_n = color_q;
`ifdef RECT_OUTLINE_EN
            wr_en_n   = !outline_q || (x_n == x0_q) || ({1'b0, x_n} == x_last) ||
                        (y_n == y0_q) || ({1'b0, y_n} == y_last);
`else
            wr_en_n   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
`ifdef RECT_OUTLINE_EN
            outline_q <= 1'b0;
`endif
            x_q      <= '0;
            y_q      <= '0;
            row_base <= '0;
        end else begin
            state    <= state_n;
            busy     <= busy_n;
            done     <= done_n;
            wr_en    <= wr_en_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            x0_q     <= x0_n;
            y0_q     <= y0_n;
            w_q      <= w_n;
            h_q      <= h_n;
            color_q  <= color_n;
`ifdef RECT_OUTLINE_EN
            outline_q <= outline_n;
`endif
            x_q      <= x_n;
            y_q      <= y_n;
            row_base <= row_n;
        end
    end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Self-checking bench for rect_fill_writer: directed corner cases plus random rectangles
// compared cycle by cycle against a clipped-rectangle model. Honours RECT_OUTLINE_EN.
module tb_rect_fill_writer;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  x0 = '0;
    logic [6:0]  y0 = '0;
    logic [7:0]  w = '0;
    logic [6:0]  h = '0;
    logic [23:0] color = '0;
`ifdef RECT_OUTLINE_EN
    logic        outline = 1'b0;
`endif
    logic        busy, done, wr_en;
    logic [14:0] wr_addr;
    logic [23:0] wr_data;

    int checks = 0;
    int failures = 0;

    rect_fill_writer #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .ADDR_W(15), .COLOR_W(24)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .x0(x0),
        .y0(y0),
        .w(w),
        .h(h),
        .color(color),
`ifdef RECT_OUTLINE_EN
        .outline(outline),
`endif
        .busy(busy),
        .done(done),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_en(wr_en)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents a command for one cycle; returns just after the sampling edge (cycle N+1).
    task automatic applyStimulus(input int cx, input int cy, input int cw, input int ch,
                                 input logic [23:0] ccol, input bit cout);
        x0    = 8'(cx);
        y0    = 7'(cy);
        w     = 8'(cw);
        h     = 7'(ch);
        color = ccol;
`ifdef RECT_OUTLINE_EN
        outline = cout;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Model: the clipped rectangle holds spanW*spanH pixels; pixel k sits at
    // (cx + k mod spanW, cy + k div spanW) and lands at address y*SCREEN_W + x.
    task automatic runCommand(input string tag, input int cx, input int cy, input int cw, input int ch,
                              input logic [23:0] ccol, input bit coutIn, input int injectAt,
                              input int abortAt, output int writes);
        int spanW, spanH, pixels, xx, yy, lastAddr;
        bit expEn, cout;
`ifdef RECT_OUTLINE_EN
        cout = coutIn;
`else
        cout = 1'b0 & coutIn;
`endif
        spanW = ((cx + cw) > SCREEN_W ? SCREEN_W : (cx + cw)) - cx;
        spanH = ((cy + ch) > SCREEN_H ? SCREEN_H : (cy + ch)) - cy;
        if (spanW < 0) spanW = 0;
        if (spanH < 0) spanH = 0;
        pixels   = spanW * spanH;
        writes   = 0;
        lastAddr = -1;

        applyStimulus(cx, cy, cw, ch, ccol, cout);
        checkOutput({tag, "_setup_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_setup_wren"}, 32'(wr_en), 32'd0);
        checkOutput({tag, "_setup_done"}, 32'(done), 32'd0);

        for (int k = 0; k < pixels; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            xx = cx + k % spanW;
            yy = cy + k / spanW;
            expEn = !cout || xx == cx || xx == cx + spanW - 1 || yy == cy || yy == cy + spanH - 1;
            checkOutput({tag, "_scan_busy"}, 32'(busy), 32'd1);
            checkOutput({tag, "_scan_done"}, 32'(done), 32'd0);
            checkOutput({tag, "_scan_wren"}, 32'(wr_en), 32'(expEn));
            if (expEn) begin
                checkOutput({tag, "_addr"}, 32'(wr_addr), 32'(yy * SCREEN_W + xx));
                checkOutput({tag, "_data"}, 32'(wr_data), 32'(ccol));
                writes++;
                lastAddr = yy * SCREEN_W + xx;
            end
            if (k == injectAt) begin
                x0 = 8'd0; y0 = 7'd0; w = 8'd1; h = 7'd1; color = 24'h123456;
                start = 1'b1;
            end
            if (abortAt > 0 && writes == abortAt) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                checkOutput({tag, "_rst_busy"}, 32'(busy), 32'd0);
                checkOutput({tag, "_rst_done"}, 32'(done), 32'd0);
                checkOutput({tag, "_rst_wren"}, 32'(wr_en), 32'd0);
                checkOutput({tag, "_rst_addr"}, 32'(wr_addr), 32'd0);
                checkOutput({tag, "_rst_data"}, 32'(wr_data), 32'd0);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    checkOutput({tag, "_post_rst_done"}, 32'(done), 32'd0);
                    checkOutput({tag, "_post_rst_wren"}, 32'(wr_en), 32'd0);
                end
                return;
            end
        end

        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_done_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done_wren"}, 32'(wr_en), 32'd0);
        if (lastAddr >= 0)
            checkOutput({tag, "_hold_addr"}, 32'(wr_addr), 32'(lastAddr));
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_idle_done"}, 32'(done), 32'd0);
            checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
            checkOutput({tag, "_idle_wren"}, 32'(wr_en), 32'd0);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_wren", 32'(wr_en), 32'd0);
        checkOutput("reset_addr", 32'(wr_addr), 32'd0);
        checkOutput("reset_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        runCommand("full", 0, 0, 160, 120, 24'hFFFFFF, 1'b0, -1, 0, n);
        checkOutput("full_count", 32'(n), 32'd19200);

        runCommand("corner", 158, 118, 5, 5, 24'h000000, 1'b0, -1, 0, n);
        checkOutput("corner_count", 32'(n), 32'd4);

        runCommand("single", 80, 60, 1, 1, 24'hFF0000, 1'b0, -1, 0, n);
        checkOutput("single_count", 32'(n), 32'd1);

        runCommand("empty_w", 10, 10, 0, 5, 24'h00FF00, 1'b0, -1, 0, n);
        checkOutput("empty_w_count", 32'(n), 32'd0);
        runCommand("empty_x", 200, 10, 5, 5, 24'h00FF00, 1'b0, -1, 0, n);
        checkOutput("empty_x_count", 32'(n), 32'd0);

        runCommand("busy_start", 5, 5, 20, 20, 24'hABCDEF, 1'b0, 50, 0, n);
        checkOutput("busy_start_count", 32'(n), 32'd400);

        runCommand("reset_mid", 30, 30, 20, 20, 24'h0F0F0F, 1'b0, -1, 10, n);
        checkOutput("reset_mid_count", 32'(n), 32'd10);

`ifdef RECT_OUTLINE_EN
        runCommand("outline", 10, 10, 4, 3, 24'h00FFFF, 1'b1, -1, 0, n);
        checkOutput("outline_count", 32'(n), 32'd10);
`endif

        for (int i = 0; i < 25; i++) begin
            runCommand("rand", int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
                       int'($urandom_range(0, 30)), int'($urandom_range(0, 20)),
                       24'($urandom), 1'($urandom), -1, 0, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
